// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the 7-segment digit bank and LED bar
//
// Purpose: segment width, LED bar width, the hex glyph table and the blank glyph
//          used by every display block on the board.
// Ports:   none (package)

package display_pkg;

  localparam int SEG_W = 7;
  localparam int LED_W = 16;

  // Segments are active-low {a,b,c,d,e,f,g}, bit 6 = a. All ones turns every segment off.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Entry n holds the glyph for nibble n: 0-9, A, b, C, d, E, F.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic logic [SEG_W-1:0] seg_glyph(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// rtl/hex7seg_decode.sv - combinational hex nibble to active-low 7-segment glyph
//
// Purpose: maps one 4-bit value onto the shared glyph table.
// Ports:
//   nibble  in   4      value to show (0..F)
//   seg     out  SEG_W  active-low {a,b,c,d,e,f,g}, seg[6] = a

module hex7seg_decode
  import display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = seg_glyph(nibble);

endmodule

// File: rtl/hex_scan_display.sv
// rtl/hex_scan_display.sv - prescaled hex counter with multiplexed 7-seg scan and LED mirror
//
// Purpose: run/stop/loadable counter with prescaler, time-multiplexed digit scanner with
//          leading-zero blanking and a selectable decimal point, plus a banked 16-bit
//          LED window onto the counter. All pin-facing outputs are registered.
// Ports:
//   clk         in   1             system clock
//   reset       in   1             asynchronous active-high reset
//   run         in   1             counter advances on prescaler tick when 1
//   clear       in   1             synchronous clear of counter and prescaler
//   load        in   1             synchronous load of load_value
//   load_value  in   COUNT_WIDTH   value for load
//   blank_lz    in   1             blank leading-zero digits when 1
//   dp_sel      in   DP_W          digit whose decimal point is lit
//   bank_sel    in   BANK_W        16-bit counter window shown on LED
//   count       out  COUNT_WIDTH   current counter value
//   overflow    out  1             one-cycle pulse after an increment wraps to 0
//   LED         out  16            counter window
//   anodes      out  NUM_DIGITS    active-low digit enables
//   seg         out  7             active-low segments, seg[6] = a
//   dp          out  1             active-low decimal point

module hex_scan_display
  import display_pkg::*;
#(
  parameter  int NUM_DIGITS  = 8,
  parameter  int COUNT_WIDTH = 4 * NUM_DIGITS,
  parameter  int COUNT_DIV   = 1,
  parameter  int SCAN_DIV    = 100000,
  localparam int DP_W        = $clog2(NUM_DIGITS),
  localparam int NUM_BANKS   = (COUNT_WIDTH + LED_W - 1) / LED_W,
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   clear,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   blank_lz,
  input  logic [DP_W-1:0]        dp_sel,
  input  logic [BANK_W-1:0]      bank_sel,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow,
  output logic [LED_W-1:0]       LED,
  output logic [NUM_DIGITS-1:0]  anodes,
  output logic [SEG_W-1:0]       seg,
  output logic                   dp
);

  localparam int PRE_W     = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SCAN_W    = $clog2(SCAN_DIV);
  localparam int IDX_W     = DP_W;
  localparam int NIB_W     = 4 * NUM_DIGITS;
  // LED window source is padded to a whole power-of-two number of banks so any
  // bank_sel value indexes in range; banks past COUNT_WIDTH read as zero.
  localparam int LED_PAD_W = LED_W * (1 << BANK_W);

  // ---------------------------------------------------------------------------
  // Prescaler: free-running regardless of run; only clear (and reset) realign it.
  // With COUNT_DIV = 1 the register stays at 0 and tick is permanently high.
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_W'(COUNT_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (clear || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Counter: clear > load > increment > hold. Only the increment path can raise
  // overflow, so a load or clear that lands on zero never pulses it.
  // ---------------------------------------------------------------------------
  logic step;

  assign step = run && tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= load_value;
      end else if (step) begin
        count    <= count + COUNT_WIDTH'(1);
        overflow <= &count;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scanner: each digit dwells SCAN_DIV clocks, index wraps after the last.
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_timer;
  logic [IDX_W-1:0]  scan_idx;
  logic              scan_wrap;

  assign scan_wrap = (scan_timer == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_timer <= '0;
      scan_idx   <= '0;
    end else if (scan_wrap) begin
      scan_timer <= '0;
      scan_idx   <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      scan_timer <= scan_timer + SCAN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Digit data path. Only the low NUM_DIGITS nibbles are displayable, so the
  // leading-zero test looks at the displayed nibbles from the current one upward.
  // ---------------------------------------------------------------------------
  logic [NIB_W-1:0]   digits;
  logic [IDX_W+1:0]   nib_base;
  logic [NIB_W-1:0]   upper;
  logic [3:0]         cur_nibble;
  logic [SEG_W-1:0]   seg_next;
  logic               blank;
  logic               dp_hit;
  logic [LED_PAD_W-1:0] led_pad;

  assign digits     = NIB_W'(count);
  assign nib_base   = {scan_idx, 2'b00};
  assign upper      = digits >> nib_base;
  assign cur_nibble = digits[nib_base +: 4];
  assign blank      = blank_lz && (scan_idx != '0) && (upper == '0);
  // scan_idx never exceeds NUM_DIGITS-1, so out-of-range dp_sel values never match.
  assign dp_hit     = (dp_sel == scan_idx);
  assign led_pad    = LED_PAD_W'(count);

  hex7seg_decode u_decode (
    .nibble (cur_nibble),
    .seg    (seg_next)
  );

  // Pin registers refresh every clock so count changes show within the dwell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anodes <= '1;
      seg    <= SEG_BLANK;
      dp     <= 1'b1;
      LED    <= '0;
    end else begin
      anodes <= blank ? '1 : ~(NUM_DIGITS'(1) << scan_idx);
      seg    <= seg_next;
      dp     <= ~(dp_hit && !blank);
      LED    <= led_pad[{bank_sel, 4'b0000} +: LED_W];
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// tb/tb_hex_scan_display.sv - self-checking bench for hex_scan_display
module tb_hex_scan_display;

  logic        clk, reset, run, clear, load, blank_lz, bank_sel;
  logic [31:0] load_value;
  logic [2:0]  dp_sel;

  logic [15:0] count0, count1, led0, led1, led2;
  logic [31:0] count2;
  logic        ovf0, ovf1, ovf2, dp0, dp1, dp2;
  logic [3:0]  an0, an1;
  logic [7:0]  an2;
  logic [6:0]  seg0, seg1, seg2;

  int total = 0;
  int bad   = 0;

  hex_scan_display #(.NUM_DIGITS(4), .COUNT_WIDTH(16), .COUNT_DIV(1), .SCAN_DIV(4)) u_dut0 (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .load(load),
    .load_value(load_value[15:0]), .blank_lz(blank_lz), .dp_sel(dp_sel[1:0]), .bank_sel(bank_sel),
    .count(count0), .overflow(ovf0), .LED(led0), .anodes(an0), .seg(seg0), .dp(dp0));

  hex_scan_display #(.NUM_DIGITS(4), .COUNT_WIDTH(16), .COUNT_DIV(3), .SCAN_DIV(4)) u_dut1 (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .load(load),
    .load_value(load_value[15:0]), .blank_lz(blank_lz), .dp_sel(dp_sel[1:0]), .bank_sel(bank_sel),
    .count(count1), .overflow(ovf1), .LED(led1), .anodes(an1), .seg(seg1), .dp(dp1));

  hex_scan_display #(.NUM_DIGITS(8), .COUNT_WIDTH(32), .COUNT_DIV(1), .SCAN_DIV(4)) u_dut2 (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .load(load),
    .load_value(load_value), .blank_lz(blank_lz), .dp_sel(dp_sel), .bank_sel(bank_sel),
    .count(count2), .overflow(ovf2), .LED(led2), .anodes(an2), .seg(seg2), .dp(dp2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Uniform views of the three instances (unused anode positions read as 1).
  logic [31:0] a_count [3];
  logic        a_ovf   [3];
  logic [15:0] a_led   [3];
  logic [7:0]  a_an    [3];
  logic [6:0]  a_seg   [3];
  logic        a_dp    [3];

  assign a_count[0] = {16'h0, count0};
  assign a_count[1] = {16'h0, count1};
  assign a_count[2] = count2;
  assign a_ovf[0] = ovf0;  assign a_ovf[1] = ovf1;  assign a_ovf[2] = ovf2;
  assign a_led[0] = led0;  assign a_led[1] = led1;  assign a_led[2] = led2;
  assign a_an[0]  = {4'hF, an0};
  assign a_an[1]  = {4'hF, an1};
  assign a_an[2]  = an2;
  assign a_seg[0] = seg0;  assign a_seg[1] = seg1;  assign a_seg[2] = seg2;
  assign a_dp[0]  = dp0;   assign a_dp[1]  = dp1;   assign a_dp[2]  = dp2;

  // ---------------------------------------------------------------------------
  // Reference model: counter value, cycles since the last clear, and cycles since
  // reset. Digit index and prescaler tick are derived arithmetically from those.
  // ---------------------------------------------------------------------------
  function automatic int nd_of(input int d);
    return (d == 2) ? 8 : 4;
  endfunction

  function automatic int cd_of(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic longint unsigned mask_of(input int d);
    return (d == 2) ? 64'hFFFF_FFFF : 64'hFFFF;
  endfunction

  function automatic logic [6:0] seg_ref(input longint unsigned v);
    case (int'(v & 64'hF))
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic int idx_of(input int d, input int cyc);
    return (cyc / 4) % nd_of(d);
  endfunction

  function automatic bit tick_of(input int d, input int pc);
    return (pc % cd_of(d)) == cd_of(d) - 1;
  endfunction

  function automatic bit blanked(input int d, input longint unsigned c, input int cyc, input logic blz);
    int i;
    i = idx_of(d, cyc);
    return blz && (i > 0) && ((c >> (4 * i)) == 0);
  endfunction

  function automatic logic [7:0] exp_an(input int d, input longint unsigned c, input int cyc, input logic blz);
    if (blanked(d, c, cyc, blz)) return 8'hFF;
    return ~(8'd1 << idx_of(d, cyc));
  endfunction

  function automatic logic exp_dp(input int d, input longint unsigned c, input int cyc, input logic blz,
                                  input logic [2:0] dps);
    int sel;
    sel = (d == 2) ? int'(dps) : int'(dps[1:0]);
    return !((idx_of(d, cyc) == sel) && !blanked(d, c, cyc, blz));
  endfunction

  function automatic logic [15:0] exp_led(input longint unsigned c, input logic bs);
    return 16'((c >> (16 * int'(bs))) & 64'hFFFF);
  endfunction

  function automatic longint unsigned next_count(input int d, input longint unsigned c, input int pc,
                                                 input logic clr, input logic ld, input logic rn,
                                                 input logic [31:0] lv);
    if (clr) return 0;
    if (ld) return 64'(lv) & mask_of(d);
    if (rn && tick_of(d, pc)) return (c + 1) & mask_of(d);
    return c;
  endfunction

  longint unsigned m_count [3];
  int              m_pc    [3];
  int              m_cyc   [3];
  logic [7:0]      e_an    [3];
  logic [6:0]      e_seg   [3];
  logic            e_dp    [3];
  logic [15:0]     e_led   [3];
  logic            e_ovf   [3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        m_count[d] <= 0;
        m_pc[d]    <= 0;
        m_cyc[d]   <= 0;
        e_an[d]    <= 8'hFF;
        e_seg[d]   <= 7'h7F;
        e_dp[d]    <= 1'b1;
        e_led[d]   <= 16'h0;
        e_ovf[d]   <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        e_an[d]    <= exp_an(d, m_count[d], m_cyc[d], blank_lz);
        e_seg[d]   <= seg_ref(m_count[d] >> (4 * idx_of(d, m_cyc[d])));
        e_dp[d]    <= exp_dp(d, m_count[d], m_cyc[d], blank_lz, dp_sel);
        e_led[d]   <= exp_led(m_count[d], bank_sel);
        e_ovf[d]   <= !clear && !load && run && tick_of(d, m_pc[d]) && (m_count[d] == mask_of(d));
        m_count[d] <= next_count(d, m_count[d], m_pc[d], clear, load, run, load_value);
        m_pc[d]    <= clear ? 0 : m_pc[d] + 1;
        m_cyc[d]   <= m_cyc[d] + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; run = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0;
    blank_lz = 1'b0; dp_sel = '0; bank_sel = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({a_count[d], a_ovf[d], a_led[d], a_an[d], a_seg[d], a_dp[d]} !==
          {32'h0, 1'b0, 16'h0, 8'hFF, 7'h7F, 1'b1}) begin
        bad++;
        $display("FAIL reset_state dut%0d got cnt=%h ovf=%b led=%h an=%b seg=%b dp=%b want 0 0 0 ff 1111111 1",
                 d, a_count[d], a_ovf[d], a_led[d], a_an[d], a_seg[d], a_dp[d]);
      end
    end
  endtask

  task automatic test_count_scan();
    logic [3:0] want_an;
    run = 1'b1;
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      want_an = ~(4'd1 << (((k - 1) / 4) % 4));
      total++;
      if (an0 !== want_an) begin
        bad++;
        $display("FAIL scan_anodes k=%0d got %b want %b", k, an0, want_an);
      end
      if (k <= 4) begin
        total++;
        if (seg0 !== seg_ref(longint'(k - 1))) begin
          bad++;
          $display("FAIL scan_seg_digit0 k=%0d got %b want %b", k, seg0, seg_ref(longint'(k - 1)));
        end
      end
    end
    total++;
    if (count0 !== 16'h0014) begin bad++; $display("FAIL count20_div1 got %h want 0014", count0); end
    total++;
    if (count1 !== 16'h0006) begin bad++; $display("FAIL count20_div3 got %h want 0006", count1); end
    total++;
    if (count2 !== 32'h14) begin bad++; $display("FAIL count20_w32 got %h want 00000014", count2); end
  endtask

  task automatic test_overflow();
    run = 1'b0; load = 1'b1; load_value = 32'hFFFF_FFFE;
    @(negedge clk);
    total++;
    if ({count0, ovf0} !== {16'hFFFE, 1'b0}) begin
      bad++; $display("FAIL ovf_load cnt=%h ovf=%b want fffe 0", count0, ovf0);
    end
    load = 1'b0; run = 1'b1;
    @(negedge clk);
    total++;
    if ({count0, ovf0} !== {16'hFFFF, 1'b0}) begin
      bad++; $display("FAIL ovf_allones cnt=%h ovf=%b want ffff 0", count0, ovf0);
    end
    @(negedge clk);
    total++;
    if ({count0, ovf0, count2, ovf2} !== {16'h0000, 1'b1, 32'h0, 1'b1}) begin
      bad++; $display("FAIL ovf_wrap cnt=%h ovf=%b cnt2=%h ovf2=%b want 0000 1 0 1", count0, ovf0, count2, ovf2);
    end
    @(negedge clk);
    total++;
    if ({count0, ovf0} !== {16'h0001, 1'b0}) begin
      bad++; $display("FAIL ovf_pulse_end cnt=%h ovf=%b want 0001 0", count0, ovf0);
    end
    run = 1'b0; load = 1'b1; load_value = 32'hFFFF_FFFF;
    @(negedge clk);
    run = 1'b1; load_value = 32'h0;
    @(negedge clk);
    total++;
    if ({count0, ovf0} !== {16'h0000, 1'b0}) begin
      bad++; $display("FAIL ovf_none_on_load cnt=%h ovf=%b want 0000 0", count0, ovf0);
    end
    run = 1'b0; load_value = 32'hFFFF_FFFF;
    @(negedge clk);
    load = 1'b0; clear = 1'b1; run = 1'b1;
    @(negedge clk);
    total++;
    if ({count0, ovf0} !== {16'h0000, 1'b0}) begin
      bad++; $display("FAIL ovf_none_on_clear cnt=%h ovf=%b want 0000 0", count0, ovf0);
    end
    clear = 1'b0; run = 1'b0;
  endtask

  task automatic test_blanking();
    int n0, n1, nb, nx, seg_err, dp_low, n2_0, n2_1, n2_b, dp_err;
    n0 = 0; n1 = 0; nb = 0; nx = 0; seg_err = 0; dp_low = 0; n2_0 = 0; n2_1 = 0; n2_b = 0; dp_err = 0;
    run = 1'b0; load = 1'b1; load_value = 32'h0000_00A0; blank_lz = 1'b1; dp_sel = 3'd3;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      case (an0)
        4'b1110: begin n0++; if (seg0 !== 7'b0000001) seg_err++; end
        4'b1101: begin n1++; if (seg0 !== 7'b0001000) seg_err++; end
        4'b1111: nb++;
        default: nx++;
      endcase
      if (dp0 !== 1'b1 || dp2 !== 1'b1) dp_low++;
      case (an2)
        8'hFE: n2_0++;
        8'hFD: n2_1++;
        8'hFF: n2_b++;
        default: nx++;
      endcase
    end
    total++;
    if (n0 != 8 || n1 != 8 || nb != 16 || nx != 0) begin
      bad++; $display("FAIL blank_dwell4 d0=%0d d1=%0d blank=%0d other=%0d want 8 8 16 0", n0, n1, nb, nx);
    end
    total++;
    if (n2_0 != 4 || n2_1 != 4 || n2_b != 24) begin
      bad++; $display("FAIL blank_dwell8 d0=%0d d1=%0d blank=%0d want 4 4 24", n2_0, n2_1, n2_b);
    end
    total++;
    if (seg_err != 0) begin bad++; $display("FAIL blank_seg errors=%0d want 0", seg_err); end
    total++;
    if (dp_low != 0) begin bad++; $display("FAIL blank_dp_hidden lit=%0d want 0", dp_low); end
    blank_lz = 1'b0;
    @(negedge clk);
    n0 = 0; dp_low = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (an0 === 4'b0111 && seg0 === 7'b0000001) n0++;
      if (dp0 === 1'b0) dp_low++;
      if ((dp0 === 1'b0) != (an0 === 4'b0111)) dp_err++;
    end
    total++;
    if (n0 != 4) begin bad++; $display("FAIL unblank_digit3 shown=%0d want 4", n0); end
    total++;
    if (dp_low != 4 || dp_err != 0) begin
      bad++; $display("FAIL unblank_dp lit=%0d misplaced=%0d want 4 0", dp_low, dp_err);
    end
  endtask

  task automatic test_prescale();
    clear = 1'b1; run = 1'b1; load = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (count1 !== 16'h0) begin bad++; $display("FAIL pre_clear got %h want 0000", count1); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      total++;
      if (count1 !== 16'(k / 3)) begin bad++; $display("FAIL pre_step k=%0d got %h want %h", k, count1, 16'(k / 3)); end
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (count1 !== 16'h0) begin bad++; $display("FAIL pre_midclear got %h want 0000", count1); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if (count1 !== 16'(k / 3)) begin bad++; $display("FAIL pre_realign k=%0d got %h want %h", k, count1, 16'(k / 3)); end
    end
    clear = 1'b1; load = 1'b1; load_value = 32'h5;
    @(negedge clk);
    total++;
    if ({count1, count0} !== 32'h0) begin
      bad++; $display("FAIL clear_beats_load got %h %h want 0000 0000", count1, count0);
    end
    clear = 1'b0; load = 1'b0; run = 1'b0;
  endtask

  task automatic test_banks_dp();
    int dp_err, dp_low, seg_err;
    dp_err = 0; dp_low = 0; seg_err = 0;
    run = 1'b0; blank_lz = 1'b0; bank_sel = 1'b0; load = 1'b1; load_value = 32'h1234_ABCD;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    total++;
    if ({led2, led0} !== {16'hABCD, 16'hABCD}) begin
      bad++; $display("FAIL led_bank0 got %h %h want abcd abcd", led2, led0);
    end
    bank_sel = 1'b1;
    @(negedge clk);
    total++;
    if ({led2, led0} !== {16'h1234, 16'h0000}) begin
      bad++; $display("FAIL led_bank1 got %h %h want 1234 0000", led2, led0);
    end
    dp_sel = 3'd2;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if ((dp2 === 1'b0) != (an2[2] === 1'b0)) dp_err++;
      if (dp2 === 1'b0) dp_low++;
      if (an2 === 8'hFB && seg2 !== 7'b1100000) seg_err++;
    end
    total++;
    if (dp_err != 0 || dp_low != 4) begin
      bad++; $display("FAIL dp_digit2 misplaced=%0d lit=%0d want 0 4", dp_err, dp_low);
    end
    total++;
    if (seg_err != 0) begin bad++; $display("FAIL seg_digit2_b errors=%0d want 0", seg_err); end
    bank_sel = 1'b0; dp_sel = '0;
  endtask

  task automatic test_reset_mid_dwell();
    bit found;
    logic [3:0] want_an;
    found = 1'b0;
    run = 1'b0; blank_lz = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (an0 === 4'b1011) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL wait_digit2 timeout an0=%b want 1011", an0); end
    reset = 1'b1;
    #1;
    total++;
    if ({an0, seg0, dp0, an2, seg2, dp2} !== {4'hF, 7'h7F, 1'b1, 8'hFF, 7'h7F, 1'b1}) begin
      bad++; $display("FAIL async_reset got an=%b seg=%b dp=%b an2=%b want 1111 1111111 1 11111111", an0, seg0, dp0, an2);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      want_an = (k <= 4) ? 4'b1110 : 4'b1101;
      total++;
      if (an0 !== want_an) begin bad++; $display("FAIL restart_dwell k=%0d got %b want %b", k, an0, want_an); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        total++;
        if ({a_count[d], a_ovf[d], a_led[d], a_an[d], a_seg[d], a_dp[d]} !==
            {32'(m_count[d]), e_ovf[d], e_led[d], e_an[d], e_seg[d], e_dp[d]}) begin
          bad++;
          $display("FAIL random n=%0d dut%0d got cnt=%h ovf=%b led=%h an=%b seg=%b dp=%b want cnt=%h ovf=%b led=%h an=%b seg=%b dp=%b",
                   n, d, a_count[d], a_ovf[d], a_led[d], a_an[d], a_seg[d], a_dp[d],
                   32'(m_count[d]), e_ovf[d], e_led[d], e_an[d], e_seg[d], e_dp[d]);
        end
      end
      reset = ($urandom_range(0, 199) == 0);
      run   = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 39) == 0);
      load  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0:       load_value = $urandom;
        1:       load_value = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: load_value = $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 15) == 0) dp_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) bank_sel = ~bank_sel;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_scan();
    test_overflow();
    test_blanking();
    test_prescale();
    test_banks_dp();
    test_reset_mid_dwell();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
Name: hex_scan_display

Overview:
Parametrised multi-digit hex display engine for the board's 7-segment bank and LED bar. It contains a run/stop/loadable counter with prescaler and a time-multiplexed digit scanner, replacing switch-selected single-digit viewing. It also provides leading-zero blanking, a selectable decimal point and a banked 16-LED mirror of the counter. It sits between board I/O (switches/buttons, already synchronised upstream) and the anode/segment/LED pins.

Parameters:
NUM_DIGITS, 8, number of 7-seg digits scanned (2..8)
COUNT_WIDTH, 4*NUM_DIGITS, counter width; one nibble per digit
COUNT_DIV, 1, clk cycles per counter increment (>=1)
SCAN_DIV, 100000, clk cycles per digit dwell (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  1 = counter advances on prescaler tick; 0 = hold
clear  in  1  synchronous clear of counter and prescaler
load  in  1  synchronous load of load_value into counter
load_value  in  COUNT_WIDTH  value for load
blank_lz  in  1  1 = blank leading-zero digits
dp_sel  in  $clog2(NUM_DIGITS)  digit index whose decimal point is lit
bank_sel  in  $clog2(ceil(COUNT_WIDTH/16)) (min 1)  16-bit window shown on LED
count  out  COUNT_WIDTH  current counter value
overflow  out  1  one-cycle pulse when counter wraps all-ones -> 0
LED  out  16  counter window
anodes  out  NUM_DIGITS  active-low digit enables
seg  out  7  active-low {a,b,c,d,e,f,g}, seg[6]=a
dp  out  1  active-low decimal point

Behaviour:
- Reset (async, active-high): count=0, prescaler=0, scan index=0, scan timer=0, overflow=0, LED=0, anodes=all 1, seg=7'h7F, dp=1.
- Counter priority per clk: clear > load > (run & tick) increment > hold. clear also zeroes the prescaler. load does not disturb the prescaler.
- Prescaler counts 0..COUNT_DIV-1 and wraps. tick=1 in the cycle where it equals COUNT_DIV-1. With COUNT_DIV=1, tick is constant 1. The prescaler runs regardless of run.
- Increment wraps modulo 2^COUNT_WIDTH. overflow is registered and asserted the cycle after count goes all-ones -> 0 by increment only, never on load or clear.
- Scan timer counts 0..SCAN_DIV-1. On wrap, the scan index advances; NUM_DIGITS-1 -> 0.
- Display outputs are registered, with 1-cycle latency from scan index/count to pins. They update every clk (not only at digit change), so count changes appear immediately.
  - anodes = ~(1<<idx).
  - seg = decode(count[4*idx+:4]).
  - dp = 0 iff idx==dp_sel.
- Leading-zero blanking: when blank_lz=1, idx>0, and nibbles idx..NUM_DIGITS-1 are all zero, anodes=all 1 and dp=1 for that dwell. Digit 0 is never blanked. dp_sel values >= NUM_DIGITS light no dp.
- LED = count[16*bank_sel +: 16]; bits beyond COUNT_WIDTH read 0. Registered, so it lags count by 1 cycle.
- Decode table (active-low abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Reset asserted mid-dwell forces all outputs to reset values immediately. Scanning restarts at digit 0 with a full dwell.

Decomposition:
- Package display_pkg: SEG_W=7, 16-entry segment constant array (table above), SEG_BLANK=7'h7F, LED_W=16.
- Sub-module hex7seg_decode: combinational nibble -> seg using the package table. Reused by future displays.
- Counter, scanner and blank logic stay in the top module.

Test Plan:
- Params NUM_DIGITS=4, COUNT_DIV=1, SCAN_DIV=4. Reset, run=1, 20 clks -> count=20 (0x14). anodes sequence 1110,1101,1011,0111 with 4-cycle dwell, 1 cycle delayed.
- load_value=16'hFFFE, load=1 for 1 clk, then run -> count FFFF, then 0000. overflow high exactly 1 cycle after the wrap. No overflow on load.
- load 16'h00A0, run=0, blank_lz=1 -> digits 0,1 show 0000001 and 0001000. Digits 2,3 anodes stay 1. With blank_lz=0, digit 3 shows 0000001.
- COUNT_DIV=3, run=1 -> count increments every 3 clks. clear mid-run -> count=0 next cycle and the next increment comes 3 clks later. clear+load together -> 0.
- COUNT_WIDTH=32: load 32'h1234ABCD, bank_sel=0 -> LED=ABCD; bank_sel=1 -> LED=1234. dp_sel=2 -> dp=0 only while anodes[2]=0.
- Assert reset during digit 2 dwell -> anodes=all 1, seg=7F, dp=1 same cycle. After release, digit 0 is driven first for a full SCAN_DIV dwell.
